// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: tracks E/M/W destinations and Tnew, raises the
// D-stage stall, drives forwarding selects and owns the mult/div busy counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int T_W         = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     d_raddr0,
  input  logic [4:0]     d_raddr1,
  input  logic [4:0]     d_waddr,
  input  logic [T_W-1:0] d_tuse0,
  input  logic [T_W-1:0] d_tuse1,
  input  logic [T_W-1:0] d_tnew,
  input  logic           d_md_use,
  input  logic           d_md_start,
  input  logic           d_md_div,
  output logic           stall,
  output logic [1:0]     fwd_d0,
  output logic [1:0]     fwd_d1,
  output logic [1:0]     fwd_e0,
  output logic [1:0]     fwd_e1,
  output logic           fwd_m1,
  output logic           md_busy
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD  = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD   = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [T_W-1:0] T_ZERO  = {T_W{1'b0}};
  localparam logic [T_W-1:0] T_ONE   = T_W'(1);
  localparam logic [T_W-1:0] T_STORE = T_W'(2);

  logic [4:0]     e_waddr_r, e_raddr0_r, e_raddr1_r, m_waddr_r, m_raddr1_r, w_waddr_r;
  logic [T_W-1:0] e_tnew_r, m_tnew_r;
  logic           e_store_r, m_store_r, e_md_start_r, e_md_div_r;
  logic [CW-1:0]  md_cnt_r;
  logic           stall_s;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    if (x == T_ZERO) sat_dec = T_ZERO;
    else             sat_dec = x - T_ONE;
  endfunction

  // A source stalls only if an in-flight producer in E or M is not ready by its Tuse.
  function automatic logic data_hazard(input logic [4:0] ra, input logic [T_W-1:0] tuse,
                                       input logic [4:0] ew, input logic [T_W-1:0] et,
                                       input logic [4:0] mw, input logic [T_W-1:0] mt);
    if (ra == 5'd0)                   data_hazard = 1'b0;
    else if (ew == ra && et > tuse)   data_hazard = 1'b1;
    else if (mw == ra && mt > tuse)   data_hazard = 1'b1;
    else                              data_hazard = 1'b0;
  endfunction

  function automatic logic [1:0] d_sel(input logic [4:0] ra,
                                       input logic [4:0] ew, input logic [T_W-1:0] et,
                                       input logic [4:0] mw, input logic [T_W-1:0] mt,
                                       input logic [4:0] ww);
    if (ra == 5'd0)    d_sel = 2'd0;
    else if (ew == ra) d_sel = (et == T_ZERO) ? 2'd1 : 2'd0;
    else if (mw == ra) d_sel = (mt == T_ZERO) ? 2'd2 : 2'd0;
    else if (ww == ra) d_sel = 2'd3;
    else               d_sel = 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] ra,
                                       input logic [4:0] mw, input logic [T_W-1:0] mt,
                                       input logic [4:0] ww);
    if (ra == 5'd0)    e_sel = 2'd0;
    else if (mw == ra) e_sel = (mt == T_ZERO) ? 2'd1 : 2'd0;
    else if (ww == ra) e_sel = 2'd2;
    else               e_sel = 2'd0;
  endfunction

  assign md_busy = (md_cnt_r != CNT_ZERO);

  // Stall and forwarding select decode.
  always_comb begin
    stall_s = 1'b0;
    fwd_d0  = 2'd0;
    fwd_d1  = 2'd0;
    fwd_e0  = 2'd0;
    fwd_e1  = 2'd0;
    fwd_m1  = 1'b0;
    stall_s = data_hazard(d_raddr0, d_tuse0, e_waddr_r, e_tnew_r, m_waddr_r, m_tnew_r)
            | data_hazard(d_raddr1, d_tuse1, e_waddr_r, e_tnew_r, m_waddr_r, m_tnew_r)
            | (d_md_use & (e_md_start_r | md_busy));
    fwd_d0  = d_sel(d_raddr0, e_waddr_r, e_tnew_r, m_waddr_r, m_tnew_r, w_waddr_r);
    fwd_d1  = d_sel(d_raddr1, e_waddr_r, e_tnew_r, m_waddr_r, m_tnew_r, w_waddr_r);
    fwd_e0  = e_sel(e_raddr0_r, m_waddr_r, m_tnew_r, w_waddr_r);
    fwd_e1  = e_sel(e_raddr1_r, m_waddr_r, m_tnew_r, w_waddr_r);
    if (m_store_r && m_raddr1_r != 5'd0 && m_raddr1_r == w_waddr_r) fwd_m1 = 1'b1;
    else                                                             fwd_m1 = 1'b0;
  end

  assign stall = stall_s;

  // Pipeline tracking registers; E takes a bubble while D is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_waddr_r    <= 5'd0;
      e_raddr0_r   <= 5'd0;
      e_raddr1_r   <= 5'd0;
      e_tnew_r     <= T_ZERO;
      e_store_r    <= 1'b0;
      e_md_start_r <= 1'b0;
      e_md_div_r   <= 1'b0;
      m_waddr_r    <= 5'd0;
      m_raddr1_r   <= 5'd0;
      m_tnew_r     <= T_ZERO;
      m_store_r    <= 1'b0;
      w_waddr_r    <= 5'd0;
    end else begin
      if (stall_s) begin
        e_waddr_r    <= 5'd0;
        e_raddr0_r   <= 5'd0;
        e_raddr1_r   <= 5'd0;
        e_tnew_r     <= T_ZERO;
        e_store_r    <= 1'b0;
        e_md_start_r <= 1'b0;
        e_md_div_r   <= 1'b0;
      end else begin
        e_waddr_r    <= d_waddr;
        e_raddr0_r   <= d_raddr0;
        e_raddr1_r   <= d_raddr1;
        e_tnew_r     <= sat_dec(d_tnew);
        e_store_r    <= (d_tuse1 == T_STORE);
        e_md_start_r <= d_md_start;
        e_md_div_r   <= d_md_start & d_md_div;
      end
      m_waddr_r  <= e_waddr_r;
      m_raddr1_r <= e_raddr1_r;
      m_tnew_r   <= sat_dec(e_tnew_r);
      m_store_r  <= e_store_r;
      w_waddr_r  <= m_waddr_r;
    end
  end

  // MD busy counter: loads as mult/div leaves E, then counts down regardless of stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     md_cnt_r <= CNT_ZERO;
    else if (e_md_start_r)         md_cnt_r <= e_md_div_r ? DIV_LD : MULT_LD;
    else if (md_cnt_r != CNT_ZERO) md_cnt_r <= md_cnt_r - CNT_ONE;
    else                           md_cnt_r <= md_cnt_r;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, multi-cycle MD/reset
// sequences, then random D-stage traffic against a pipeline-occupancy model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_raddr0, d_raddr1, d_waddr;
  logic [2:0] d_tuse0, d_tuse1, d_tnew;
  logic       d_md_use, d_md_start, d_md_div;
  logic       stall, fwd_m1, md_busy;
  logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .T_W(3)) dut (
    .clk(clk), .reset(reset),
    .d_raddr0(d_raddr0), .d_raddr1(d_raddr1), .d_waddr(d_waddr),
    .d_tuse0(d_tuse0), .d_tuse1(d_tuse1), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .fwd_d0(fwd_d0), .fwd_d1(fwd_d1), .fwd_e0(fwd_e0),
    .fwd_e1(fwd_e1), .fwd_m1(fwd_m1), .md_busy(md_busy)
  );

  typedef struct {
    int r0, r1, w, tu0, tu1, tn;
    bit mu, ms, md;
  } ins_t;

  typedef struct {
    ins_t i;
    int   st, d0, d1, e0, e1, m1;
  } vec_t;

  // Reference model: one record per occupied stage (0=E, 1=M, 2=W).
  typedef struct {
    int w, tn, r0, r1;
    bit store, ms, md;
  } stg_t;

  stg_t pipe[3];
  int   mdc;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(int r0, int r1, int w, int tu0, int tu1, int tn,
                              bit mu = 1'b0, bit ms = 1'b0, bit md = 1'b0);
    ins_t x;
    x.r0 = r0; x.r1 = r1; x.w = w; x.tu0 = tu0; x.tu1 = tu1; x.tn = tn;
    x.mu = mu; x.ms = ms; x.md = md;
    return x;
  endfunction

  function automatic vec_t mkv(ins_t i, int st, int d0, int d1, int e0, int e1, int m1);
    vec_t v;
    v.i = i; v.st = st; v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1; v.m1 = m1;
    return v;
  endfunction

  task automatic drive(input ins_t x);
    d_raddr0 = 5'(x.r0); d_raddr1 = 5'(x.r1); d_waddr = 5'(x.w);
    d_tuse0 = 3'(x.tu0); d_tuse1 = 3'(x.tu1); d_tnew = 3'(x.tn);
    d_md_use = x.mu; d_md_start = x.ms; d_md_div = x.md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int d0, input int d1,
                         input int e0, input int e1, input int m1, input int busy);
    chk({tag, " stall"},   int'(stall),   st);
    chk({tag, " fwd_d0"},  int'(fwd_d0),  d0);
    chk({tag, " fwd_d1"},  int'(fwd_d1),  d1);
    chk({tag, " fwd_e0"},  int'(fwd_e0),  e0);
    chk({tag, " fwd_e1"},  int'(fwd_e1),  e1);
    chk({tag, " fwd_m1"},  int'(fwd_m1),  m1);
    chk({tag, " md_busy"}, int'(md_busy), busy);
  endtask

  function automatic int sat_dec(int x);
    return (x == 0) ? 0 : x - 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    mdc = 0;
  endtask

  // Expected outputs for the instruction x currently in D.
  task automatic model_eval(input ins_t x, output int st, output int d0, output int d1,
                            output int e0, output int e1, output int m1, output int busy);
    int ra[2], tu[2], dsel[2], esel[2], era[2];
    ra[0] = x.r0; ra[1] = x.r1; tu[0] = x.tu0; tu[1] = x.tu1;
    era[0] = pipe[0].r0; era[1] = pipe[0].r1;
    st = 0;
    for (int i = 0; i < 2; i++) begin
      dsel[i] = 0;
      esel[i] = 0;
      if (ra[i] != 0)
        for (int s = 0; s < 2; s++)
          if (pipe[s].w == ra[i] && pipe[s].tn > tu[i]) st = 1;
      if (ra[i] != 0)
        for (int s = 2; s >= 0; s--)
          if (pipe[s].w == ra[i]) dsel[i] = (s == 2 || pipe[s].tn == 0) ? s + 1 : 0;
      if (era[i] != 0)
        for (int s = 2; s >= 1; s--)
          if (pipe[s].w == era[i]) esel[i] = (s == 2 || pipe[s].tn == 0) ? s : 0;
    end
    if (x.mu && (pipe[0].ms || mdc > 0)) st = 1;
    d0 = dsel[0]; d1 = dsel[1]; e0 = esel[0]; e1 = esel[1];
    m1 = (pipe[1].r1 != 0 && pipe[1].r1 == pipe[2].w && pipe[1].store) ? 1 : 0;
    busy = (mdc > 0) ? 1 : 0;
  endtask

  task automatic model_clock(input ins_t x, input int st);
    if (pipe[0].ms) mdc = pipe[0].md ? 10 : 5;
    else if (mdc > 0) mdc--;
    pipe[2] = pipe[1]; pipe[2].tn = sat_dec(pipe[2].tn);
    pipe[1] = pipe[0]; pipe[1].tn = sat_dec(pipe[1].tn);
    if (st != 0) pipe[0] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    else pipe[0] = '{x.w, sat_dec(x.tn), x.r0, x.r1, (x.tu1 == 2), x.ms, x.ms & x.md};
  endtask

  // Hold an MD reader behind a mult/div and count stall and busy cycles.
  task automatic md_seq(input string nm, input ins_t start, input ins_t rd,
                        input int exp_stall, input int exp_busy);
    int  stalls = 0, busy = 0;
    bit  done = 1'b0;
    drive(start);
    @(negedge clk);
    chk({nm, " start no stall"}, int'(stall), 0);
    step();
    drive(rd);
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge clk);
      if (md_busy) busy++;
      if (!stall) done = 1'b1;
      else begin
        stalls++;
        step();
      end
    end
    chk({nm, " finished"}, int'(done), 1);
    chk({nm, " stall cycles"}, stalls, exp_stall);
    chk({nm, " busy cycles"}, busy, exp_busy);
    step();
  endtask

  ins_t NOP, LW1, ADDU, LUI2, BEQ2, LW3, BEQ3, LW6, SW6, ADD0, RD0, LUI7, RD7;
  ins_t MULT, DIV, MFLO;
  vec_t tbl[20];

  initial begin
    int st, d0, d1, e0, e1, m1, busy;
    ins_t x;
    int tu_opts[4];

    NOP  = mk(0, 0, 0, 7, 7, 0);
    LW1  = mk(0, 0, 1, 1, 7, 3);
    ADDU = mk(1, 5, 4, 1, 1, 2);
    LUI2 = mk(0, 0, 2, 7, 7, 1);
    BEQ2 = mk(2, 0, 0, 0, 0, 0);
    LW3  = mk(0, 0, 3, 1, 7, 3);
    BEQ3 = mk(3, 3, 0, 0, 0, 0);
    LW6  = mk(0, 0, 6, 1, 7, 3);
    SW6  = mk(0, 6, 0, 1, 2, 0);
    ADD0 = mk(0, 0, 0, 7, 7, 3);
    RD0  = mk(0, 0, 0, 0, 0, 0);
    LUI7 = mk(0, 0, 7, 7, 7, 1);
    RD7  = mk(7, 0, 0, 1, 7, 0);
    MULT = mk(0, 0, 0, 7, 7, 0, 1'b1, 1'b1, 1'b0);
    DIV  = mk(0, 0, 0, 7, 7, 0, 1'b1, 1'b1, 1'b1);
    MFLO = mk(0, 0, 9, 7, 7, 2, 1'b1, 1'b0, 1'b0);

    //              instr  st d0 d1 e0 e1 m1
    tbl[0]  = mkv(LW1,  0, 0, 0, 0, 0, 0);  // load-use: one stall, then W->E
    tbl[1]  = mkv(ADDU, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(ADDU, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(NOP,  0, 0, 0, 2, 0, 0);
    tbl[4]  = mkv(LUI2, 0, 0, 0, 0, 0, 0);  // lui -> beq: E->D, then M->E
    tbl[5]  = mkv(BEQ2, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mkv(NOP,  0, 0, 0, 1, 0, 0);
    tbl[7]  = mkv(LW3,  0, 0, 0, 0, 0, 0);  // lw -> beq: two stalls, then W->D
    tbl[8]  = mkv(BEQ3, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(BEQ3, 1, 0, 0, 0, 0, 0);
    tbl[10] = mkv(BEQ3, 0, 3, 3, 0, 0, 0);
    tbl[11] = mkv(LW6,  0, 0, 0, 0, 0, 0);  // lw -> sw: store data via W->M
    tbl[12] = mkv(SW6,  0, 0, 0, 0, 0, 0);
    tbl[13] = mkv(NOP,  0, 0, 0, 0, 0, 0);
    tbl[14] = mkv(NOP,  0, 0, 0, 0, 0, 1);
    tbl[15] = mkv(ADD0, 0, 0, 0, 0, 0, 0);  // $0 is never a hazard
    tbl[16] = mkv(RD0,  0, 0, 0, 0, 0, 0);
    tbl[17] = mkv(LUI7, 0, 0, 0, 0, 0, 0);  // two producers of $7: E wins
    tbl[18] = mkv(LUI7, 0, 0, 0, 0, 0, 0);
    tbl[19] = mkv(RD7,  0, 1, 0, 0, 0, 0);

    tu_opts[0] = 0; tu_opts[1] = 1; tu_opts[2] = 2; tu_opts[3] = 7;

    reset = 1'b1;
    drive(LW1);
    step();
    step();
    @(negedge clk);
    chk_all("in reset", int'(stall), 0, 0, 0, 0, 0, 0);
    chk({"in reset", " stall"}, int'(stall), 0);
    step();
    reset = 1'b0;
    drive(NOP);
    @(negedge clk);
    chk_all("after reset", 0, 0, 0, 0, 0, 0, 0);
    step();

    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].i);
      @(negedge clk);
      chk_all($sformatf("row%0d", k), tbl[k].st, tbl[k].d0, tbl[k].d1,
              tbl[k].e0, tbl[k].e1, tbl[k].m1, 0);
      step();
    end

    for (int k = 0; k < 3; k++) begin drive(NOP); step(); end
    md_seq("mult", MULT, MFLO, 6, 5);
    for (int k = 0; k < 3; k++) begin drive(NOP); step(); end
    md_seq("div", DIV, MFLO, 11, 10);
    for (int k = 0; k < 3; k++) begin drive(NOP); step(); end

    // Reset in the middle of a multiply, counter at 3.
    drive(MULT);
    step();
    drive(MFLO);
    step();
    step();
    step();
    @(negedge clk);
    chk("pre-reset busy", int'(md_busy), 1);
    chk("pre-reset stall", int'(stall), 1);
    #1 reset = 1'b1;
    #1;
    chk("async reset busy", int'(md_busy), 0);
    chk("async reset stall", int'(stall), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mflo after reset stall", int'(stall), 0);
    chk("mflo after reset busy", int'(md_busy), 0);
    step();

    // Random traffic against the model, from a fresh reset.
    reset = 1'b1;
    drive(NOP);
    step();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      x.r0  = $urandom_range(0, 3);
      x.r1  = $urandom_range(0, 3);
      x.w   = $urandom_range(0, 3);
      x.tu0 = tu_opts[$urandom_range(0, 3)];
      x.tu1 = tu_opts[$urandom_range(0, 3)];
      x.tn  = $urandom_range(0, 3);
      x.ms  = ($urandom_range(0, 15) == 0);
      x.mu  = x.ms | ($urandom_range(0, 7) == 0);
      x.md  = x.ms & ($urandom_range(0, 1) == 1);
      drive(x);
      model_eval(x, st, d0, d1, e0, e1, m1, busy);
      @(negedge clk);
      chk_all($sformatf("rand%0d", c), st, d0, d1, e0, e1, m1, busy);
      step();
      model_clock(x, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
